// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: fades an 8-LED PWM bank between OFF/SOLID/SWEEP/BLINK display modes
module led_mode_sequencer #(
    parameter int PRE_SHIFT  = 16,
    parameter int FADE_SHIFT = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_rate,
    output logic       busy,
    output logic [1:0] mode_q,
    output logic [7:0] led
);
    localparam int PW = PRE_SHIFT + 4;
    typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} state_t;
    state_t                state, state_n;
    logic [PW-1:0]         pre_ctr;
    logic [FADE_SHIFT-1:0] fade_ctr;
    logic [8:0]            phase;
    logic [7:0]            pwm_ctr;
    logic [4:0]            gain;
    logic [3:0]            rate_q, pend_rate;
    logic [1:0]            pend_mode;
    logic                  accept, phase_tick, fade_tick, fading;
    logic [8:0]            r [8];
    logic [7:0]            lvl [8];
    logic [7:0]            duty [8];

    assign cmd_ready  = state == RUN;
    assign busy       = !cmd_ready;
    assign accept     = cmd_valid && cmd_ready;
    // (rate_q+1)<<PRE_SHIFT minus one is just rate_q followed by PRE_SHIFT ones
    assign phase_tick = pre_ctr == {rate_q, {PRE_SHIFT{1'b1}}};
    assign fade_tick  = &fade_ctr;
    assign fading     = state == FADE_OUT || state == FADE_IN;

    // next-state: only a mode change triggers the fade-out/switch/fade-in sequence
    always_comb begin
        state_n = state;
        case (state)
            RUN:      state_n = (accept && cmd_mode != mode_q) ? FADE_OUT : RUN;
            FADE_OUT: state_n = (fade_tick && gain == 5'd1) ? SWITCH : FADE_OUT;
            SWITCH:   state_n = FADE_IN;
            FADE_IN:  state_n = (fade_tick && gain == 5'd15) ? RUN : FADE_IN;
            default:  state_n = RUN;
        endcase
    end

    // sequencer state, counters, gain and command latching; later assignments override
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            mode_q    <= 2'd0;
            rate_q    <= 4'd0;
            pend_mode <= 2'd0;
            pend_rate <= 4'd0;
            gain      <= 5'd16;
            phase     <= 9'd0;
            pwm_ctr   <= 8'd0;
            pre_ctr   <= '0;
            fade_ctr  <= '0;
        end else begin
            state    <= state_n;
            pwm_ctr  <= pwm_ctr + 8'd1;
            pre_ctr  <= phase_tick ? '0 : pre_ctr + PW'(1);
            phase    <= phase + 9'(phase_tick);
            fade_ctr <= fading ? fade_ctr + FADE_SHIFT'(1) : fade_ctr;
            if (state == FADE_OUT && fade_tick) gain <= gain - 5'd1;
            if (state == FADE_IN && fade_tick) gain <= gain + 5'd1;
            if (accept && cmd_mode == mode_q) begin
                rate_q  <= cmd_rate;
                pre_ctr <= '0;
            end
            if (accept && cmd_mode != mode_q) begin
                pend_mode <= cmd_mode;
                pend_rate <= cmd_rate;
                fade_ctr  <= '0;
            end
            if (state == SWITCH) begin
                mode_q   <= pend_mode;
                rate_q   <= pend_rate;
                phase    <= 9'd0;
                pre_ctr  <= '0;
                fade_ctr <= '0;
            end
        end
    end

    // per-LED brightness for the displayed mode, scaled by the fade gain
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            r[i]    = phase + 9'(i * 64);
            lvl[i]  = mode_q == 2'd0 ? 8'd0 :
                      mode_q == 2'd1 ? 8'd255 :
                      mode_q == 2'd2 ? (r[i][8] ? ~r[i][7:0] : r[i][7:0]) :
                      ((phase[8] ^ i[0]) ? 8'd255 : 8'd0);
            duty[i] = 8'((13'(lvl[i]) * 13'(gain)) >> 4);
        end
    end

    // registered PWM compare against the free-running ramp
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) led[i] <= duty[i] > pwm_ctr;
        end
    end
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: directed checks of fades, mode levels, rate changes and reset
module tb_led_mode_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0] a_mode = 2'd0, b_mode = 2'd0;
    logic [3:0] a_rate = 4'd0, b_rate = 4'd0;
    logic       a_ready, b_ready, a_busy, b_busy;
    logic [1:0] a_mode_q, b_mode_q;
    logic [7:0] a_led, b_led;
    int         checks = 0;
    int         failures = 0;

    led_mode_sequencer #(.PRE_SHIFT(2), .FADE_SHIFT(2)) u_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_mode(a_mode),
        .cmd_rate(a_rate), .busy(a_busy), .mode_q(a_mode_q), .led(a_led)
    );

    led_mode_sequencer #(.PRE_SHIFT(8), .FADE_SHIFT(2)) u_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_mode(b_mode),
        .cmd_rate(b_rate), .busy(b_busy), .mode_q(b_mode_q), .led(b_led)
    );

    always #5 clk = ~clk;

    task automatic wait_idle_a(output int n);
        n = 0;
        while (a_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_led !== 8'd0) begin failures++; $display("FAIL reset_led got=%0d exp=0", a_led); end
        checks++; if (a_mode_q !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", a_mode_q); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", a_busy); end
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", a_ready); end
        checks++; if (b_ready !== 1'b1 || b_led !== 8'd0) begin failures++; $display("FAIL reset_b got ready=%0b led=%0d exp 1/0", b_ready, b_led); end
    endtask

    task automatic test_solid;
        int c0 = 0, c1 = 0;
        int hi[8] = '{default: 0};
        @(negedge clk);
        a_valid = 1'b1; a_mode = 2'd1; a_rate = 4'd0;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL solid_busy_rise got=%0b exp=1", a_busy); end
        for (int k = 0; k < 400 && a_busy; k++) begin
            if (a_mode_q == 2'd0) c0++; else c1++;
            @(negedge clk);
        end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL solid_timeout busy=%0b exp=0", a_busy); end
        checks++; if (c0 != 65) begin failures++; $display("FAIL solid_fade_out_cycles got=%0d exp=65", c0); end
        checks++; if (c1 != 64) begin failures++; $display("FAIL solid_fade_in_cycles got=%0d exp=64", c1); end
        checks++; if (a_mode_q !== 2'd1) begin failures++; $display("FAIL solid_mode got=%0d exp=1", a_mode_q); end
        repeat (256) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) hi[i] += int'(a_led[i]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (hi[i] != 255) begin failures++; $display("FAIL solid_duty led%0d got=%0d exp=255", i, hi[i]); end
        end
    endtask

    task automatic test_sweep_profile;
        int n = 0;
        int hi[8] = '{default: 0};
        int exp_hi[8] = '{0, 64, 128, 192, 255, 191, 127, 63};
        @(negedge clk);
        b_valid = 1'b1; b_mode = 2'd2; b_rate = 4'd15;
        @(negedge clk);
        b_valid = 1'b0;
        while (b_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++; if (b_busy !== 1'b0 || b_mode_q !== 2'd2) begin failures++; $display("FAIL sweep_settle busy=%0b mode=%0d exp 0/2", b_busy, b_mode_q); end
        repeat (256) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) hi[i] += int'(b_led[i]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (hi[i] != exp_hi[i]) begin failures++; $display("FAIL sweep_duty led%0d got=%0d exp=%0d", i, hi[i], exp_hi[i]); end
        end
    endtask

    task automatic test_rate_change;
        int n;
        logic [8:0] p0;
        @(negedge clk);
        a_valid = 1'b1; a_mode = 2'd2; a_rate = 4'd0;
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle_a(n);
        checks++; if (a_busy !== 1'b0 || a_mode_q !== 2'd2) begin failures++; $display("FAIL rate_setup busy=%0b mode=%0d exp 0/2", a_busy, a_mode_q); end
        a_valid = 1'b1; a_mode = 2'd2; a_rate = 4'd3;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rate_ready got=%0b exp=1", a_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        p0 = u_a.phase;
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rate_no_fade busy=%0b exp=0", a_busy); end
        repeat (15) @(negedge clk);
        checks++; if (u_a.phase !== p0) begin failures++; $display("FAIL rate_hold phase=%0d exp=%0d", u_a.phase, p0); end
        @(negedge clk);
        checks++; if (u_a.phase !== p0 + 9'd1) begin failures++; $display("FAIL rate_tick1 phase=%0d exp=%0d", u_a.phase, p0 + 9'd1); end
        repeat (16) @(negedge clk);
        checks++; if (u_a.phase !== p0 + 9'd2 || a_busy !== 1'b0) begin failures++; $display("FAIL rate_tick2 phase=%0d busy=%0b exp=%0d/0", u_a.phase, a_busy, p0 + 9'd2); end
    endtask

    task automatic test_held_cmd;
        int c = 0, rdy = 0;
        @(negedge clk);
        a_valid = 1'b1; a_mode = 2'd3; a_rate = 4'd1;
        @(negedge clk);
        a_mode = 2'd1; a_rate = 4'd0;
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL held_busy got=%0b exp=1", a_busy); end
        while (a_busy && c < 400) begin
            c++;
            if (a_ready) rdy++;
            @(negedge clk);
        end
        checks++; if (c != 129) begin failures++; $display("FAIL held_seq_len got=%0d exp=129", c); end
        checks++; if (rdy != 0) begin failures++; $display("FAIL held_ready_while_busy got=%0d exp=0", rdy); end
        checks++; if (a_mode_q !== 2'd3 || a_ready !== 1'b1) begin failures++; $display("FAIL held_after mode=%0d ready=%0b exp 3/1", a_mode_q, a_ready); end
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL held_accept busy=%0b exp=1", a_busy); end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        repeat (97) @(negedge clk);
        checks++; if (u_a.gain !== 5'd8 || a_mode_q !== 2'd1 || a_busy !== 1'b1) begin failures++; $display("FAIL mid_setup gain=%0d mode=%0d busy=%0b exp 8/1/1", u_a.gain, a_mode_q, a_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (a_led !== 8'd0) begin failures++; $display("FAIL mid_led got=%0d exp=0", a_led); end
        checks++; if (a_mode_q !== 2'd0) begin failures++; $display("FAIL mid_mode got=%0d exp=0", a_mode_q); end
        checks++; if (a_busy !== 1'b0 || a_ready !== 1'b1) begin failures++; $display("FAIL mid_busy busy=%0b ready=%0b exp 0/1", a_busy, a_ready); end
        repeat (40) begin
            @(negedge clk);
            if (a_busy || a_mode_q != 2'd0 || a_led != 8'd0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mid_pending_lost bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset;
        test_solid;
        test_sweep_profile;
        test_rate_change;
        test_held_cmd;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
